aes_decrypt_iterative: RTL and testbench
========================================

Name: aes_decrypt_iterative

Overview:
- Iterative AES-128 decryption core, one round per clock.
- Inverse counterpart of the encrypt datapath: uses InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
- Round keys come from an external precomputed key schedule through an index/lookup interface.
- Start/busy/done handshake; one 128-bit block in flight at a time.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported; key_idx counts down from NR to 0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; CipherIn is sampled on the same edge.
- CipherIn  input  128  ciphertext block; byte 0 is [127:120], column-major per FIPS-197.
- key_idx  output  4  index of the round key required this cycle (0..10).
- RoundKey  input  128  round key for key_idx, valid combinationally in the same cycle.
- busy  output  1  high while rounds are in progress.
- done  output  1  one-cycle pulse when PlainOut is updated.
- PlainOut  output  128  decrypted block; holds its value until the next completion.

Behaviour:
- Reset values (asynchronous):
  - busy=0, done=0, PlainOut=0.
  - Internal state register=0; round counter=NR; FSM=IDLE.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - key_idx=NR.
  - On start (edge E0): state <= CipherIn ^ RoundKey, round counter <= NR-1, busy <= 1, go to ROUND.
- ROUND (edges E1..E9):
  - key_idx = round counter r.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ RoundKey).
  - Decrement r; when r==1 at the edge, go to FINAL.
- FINAL (edge E10):
  - key_idx=0.
  - PlainOut <= InvSubBytes(InvShiftRows(state)) ^ RoundKey.
  - done <= 1, busy <= 0, go to IDLE.
- Latency: start at E0 gives done high in the cycle after E10, i.e. 10 clocks after the start edge.
- Throughput: one block per 11 cycles when start is asserted in the done cycle.
- done is high for exactly one cycle and is cleared on the next edge.
- start while busy=1 is ignored; the in-flight operation and CipherIn sampling are unaffected.
- start in the done cycle (FSM is IDLE) is accepted normally; done still falls on that edge.
- key_idx is a pure function of FSM/counter state; it never glitches to an out-of-range value (>10).
- reset asserted mid-operation: immediate return to reset values; no done pulse. The next start after reset deassertion behaves normally.
- InvMixColumns uses GF(2^8) with polynomial 0x11B: multipliers 0E, 0B, 0D, 09 via xtime chains, purely combinational within the round.
- InvShiftRows: row n rotates right by n bytes.
- InvSubBytes: 256-entry inverse S-box, one instance per byte (16 instances).
- No X on any output after reset, including when RoundKey is undriven while idle.

Test Plan:
- FIPS-197 C.1:
  - Key schedule from key 000102030405060708090a0b0c0d0e0f.
  - CipherIn=69c4e0d86a7b0430d8cdb78070b4c55a, start at E0.
  - Expect done exactly 10 clocks later, PlainOut=00112233445566778899aabbccddeeff, busy high for E1..E10 cycles only.
- FIPS-197 Appendix B:
  - Key 2b7e151628aed2a6abf7158809cf4f3c, CipherIn=3925841d02dc09fbdc118597196a0b32.
  - Expect PlainOut=3243f6a8885a308d313198a2e0370734.
  - Expect key_idx sequence 10,9,...,1,0 on consecutive cycles from E0.
- Back-to-back:
  - Start the B vector in the done cycle of the C.1 vector.
  - Expect both results correct; second done 11 cycles after the first; PlainOut holds the C.1 result until the second done.
- Start while busy:
  - Pulse start with CipherIn=all-ones at E5 of a C.1 operation.
  - Expect it ignored; C.1 result unchanged; no extra done.
- Reset mid-operation:
  - Assert reset asynchronously at E6.
  - Expect busy=0, done=0, PlainOut=0 immediately and no done pulse.
  - After deassertion, the C.1 vector completes correctly.
- Hold:
  - After done, keep start=0 for 20 cycles.
  - Expect PlainOut stable, done=0, busy=0, key_idx=10 throughout.

Source files
------------

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys fetched by index.
// Latency: done pulses 10 clocks after the start edge; 11-cycle throughput when restarted in the done cycle.
// Backpressure: none; start is ignored while busy, PlainOut holds until the next completion.
module aes_decrypt_iterative #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] CipherIn,
    output logic [3:0]   key_idx,
    input  logic [127:0] RoundKey,
    output logic         busy,
    output logic         done,
    output logic [127:0] PlainOut
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

    // Inverse S-box; entry n sits at bits [8*(255-n) +: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    fsm_t         fsm, fsm_nxt;
    logic [127:0] st;
    logic [3:0]   rnd;
    logic [127:0] sr, sb, ark, mc;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (row r, column c) lives at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Multiplies by 09/0B/0D/0E are built from the x2/x4/x8 xtime chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    // Shared round datapath: the final round taps ark, full rounds take mc.
    assign sr  = inv_shift_rows(st);
    assign sb  = inv_sub_bytes(sr);
    assign ark = sb ^ RoundKey;
    assign mc  = inv_mix_columns(ark);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next-state and key index; key_idx depends only on registered state so it never leaves 0..NR.
    always_comb begin
        fsm_nxt = fsm;
        key_idx = 4'(NR);
        case (fsm)
            IDLE: begin
                key_idx = 4'(NR);
                if (start) fsm_nxt = ROUND;
            end
            ROUND: begin
                key_idx = rnd;
                if (rnd == 4'd1) fsm_nxt = FINAL;
            end
            FINAL: begin
                key_idx = 4'd0;
                fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Block state, round counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= '0;
            rnd      <= 4'(NR);
            busy     <= 1'b0;
            done     <= 1'b0;
            PlainOut <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        st   <= CipherIn ^ RoundKey;
                        rnd  <= 4'(NR - 1);
                        busy <= 1'b1;
                    end
                end
                ROUND: begin
                    st  <= mc;
                    rnd <= rnd - 4'd1;
                end
                FINAL: begin
                    PlainOut <= ark;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    rnd      <= 4'(NR);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
module tb_aes_decrypt_iterative;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] CipherIn;
    logic [3:0]   key_idx;
    logic [127:0] RoundKey;
    logic         busy;
    logic         done;
    logic [127:0] PlainOut;

    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk_tab [4][11];
    logic [1:0]   key_sel;

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic checking = 1'b0;

    always #5 clk = ~clk;

    aes_decrypt_iterative #(.NR(10)) dut (
        .clk(clk), .reset(reset), .start(start), .CipherIn(CipherIn),
        .key_idx(key_idx), .RoundKey(RoundKey), .busy(busy), .done(done),
        .PlainOut(PlainOut)
    );

    // External key schedule lookup.
    assign RoundKey = (key_idx <= 4'd10) ? rk_tab[key_sel][key_idx] : {4{32'hdeadbeef}};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    task automatic expand_key(input logic [127:0] key, input int set);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) rk_tab[set][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // Textbook inverse cipher on a 4x4 byte matrix.
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input int set);
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   cf [4];
        logic [127:0] v, o;
        cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        v = ct ^ rk_tab[set][10];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) m[r][c] = v[127-8*(4*c+r) -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            v = rk_tab[set][rd];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = isbox[m[r][(c - r + 4) % 4]] ^ v[127-8*(4*c+r) -: 8];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rd == 0) m[r][c] = t[r][c];
                    else begin
                        m[r][c] = 8'h00;
                        for (int j = 0; j < 4; j++) m[r][c] = m[r][c] ^ gmul(cf[(j - r + 4) % 4], t[j][c]);
                    end
                end
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = m[r][c];
        return o;
    endfunction

    // Cycle-level expectation: blocks accepted only when idle, finish ten edges later.
    int           remaining;
    logic [127:0] pending, exp_plain;
    logic         exp_busy, exp_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= 0;
            exp_busy  <= 1'b0;
            exp_done  <= 1'b0;
            exp_plain <= '0;
        end else begin
            exp_done <= 1'b0;
            if (remaining == 0) begin
                if (start) begin
                    remaining <= 10;
                    pending   <= model_decrypt(CipherIn, int'(key_sel));
                    exp_busy  <= 1'b1;
                end
            end else begin
                remaining <= remaining - 1;
                if (remaining == 1) begin
                    exp_done  <= 1'b1;
                    exp_busy  <= 1'b0;
                    exp_plain <= pending;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the expectation.
    always @(negedge clk) begin
        if (checking) begin
            check("busy", {127'd0, busy}, {127'd0, exp_busy});
            check("done", {127'd0, done}, {127'd0, exp_done});
            check("key_idx", {124'd0, key_idx}, (remaining == 0) ? 128'd10 : 128'(remaining - 1));
            check("plain_out", PlainOut, exp_plain);
            if (done) done_cnt++;
        end
    end

    // Caller sits at a negedge; start is sampled on the following posedge.
    task automatic start_op(input logic [127:0] ct, input logic [1:0] ks);
        start    = 1'b1;
        CipherIn = ct;
        key_sel  = ks;
        @(negedge clk);
        start    = 1'b0;
        CipherIn = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) check("done_timeout", 128'd0, 128'd1);
    endtask

    int           lat, d0;
    logic [127:0] ct, exp, held;
    logic [1:0]   ks;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        CipherIn = '0;
        key_sel  = 2'd0;
        build_sbox();
        expand_key(C1_KEY, 0);
        expand_key(B_KEY, 1);
        expand_key({$urandom, $urandom, $urandom, $urandom}, 2);
        expand_key({$urandom, $urandom, $urandom, $urandom}, 3);

        // Pin the reference model to published values.
        check("model_sbox0", {120'd0, sbox[0]}, 128'h63);
        check("model_isbox0", {120'd0, isbox[0]}, 128'h52);
        check("model_rk10_b", rk_tab[1][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_rk10_c1", rk_tab[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("model_c1", model_decrypt(C1_CT, 0), C1_PT);
        check("model_b", model_decrypt(B_CT, 1), B_PT);

        checking = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_plain", PlainOut, 128'd0);
        check("reset_key_idx", {124'd0, key_idx}, 128'd10);
        reset = 1'b0;
        @(negedge clk);

        // C.1 vector, then B started in the done cycle.
        start_op(C1_CT, 2'd0);
        wait_done(lat);
        check("c1_latency", 128'(lat), 128'd10);
        check("c1_plain", PlainOut, C1_PT);
        start_op(B_CT, 2'd1);
        check("b2b_hold_c1", PlainOut, C1_PT);
        wait_done(lat);
        check("b2b_gap", 128'(lat + 1), 128'd11);
        check("b_plain", PlainOut, B_PT);
        @(negedge clk);

        // Start pulse while busy must be ignored.
        start_op(C1_CT, 2'd0);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        CipherIn = '1;
        @(negedge clk);
        start    = 1'b0;
        d0 = done_cnt;
        wait_done(lat);
        check("busy_start_plain", PlainOut, C1_PT);
        repeat (15) @(negedge clk);
        check("busy_start_dones", 128'(done_cnt - d0), 128'd1);

        // Asynchronous reset mid-operation.
        start_op(C1_CT, 2'd0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_plain", PlainOut, 128'd0);
        check("rst_key_idx", {124'd0, key_idx}, 128'd10);
        @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        check("rst_no_done", 128'(done_cnt - d0), 128'd0);
        start_op(C1_CT, 2'd0);
        wait_done(lat);
        check("rst_then_c1", PlainOut, C1_PT);

        // Hold: idle for 20 cycles after completion.
        held = PlainOut;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_plain", PlainOut, held);
            check("hold_flags", {123'd0, done, busy, key_idx}, {123'd0, 2'b00, 4'd10});
        end

        // Randomized blocks, keys, gaps and ignored starts.
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ct  = {$urandom, $urandom, $urandom, $urandom};
            ks  = 2'($urandom_range(0, 3));
            exp = model_decrypt(ct, int'(ks));
            start_op(ct, ks);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 7)) @(negedge clk);
                if (!done) begin
                    start    = 1'b1;
                    CipherIn = {$urandom, $urandom, $urandom, $urandom};
                    @(negedge clk);
                    start    = 1'b0;
                end
            end
            wait_done(lat);
            check("rand_plain", PlainOut, exp);
        end
        repeat (3) @(negedge clk);
        checking = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
